// File: rtl/membus_ram_responder_if.sv
// Membus request/response bundle between an initiator and the RAM responder.
// Request phase uses valid/ready; the response is a one-cycle rvalid pulse.
interface membus_ram_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    bus_valid;
  logic                    bus_ready;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic                    bus_wen;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic [DATA_WIDTH/8-1:0] bus_wmask;
  logic                    bus_rvalid;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/membus_ram_responder.sv
// Single-outstanding RAM responder: one rvalid pulse LATENCY cycles after each accept.
// Ready is low from the accept until the response cycle has passed; writes commit at the accept edge.
module membus_ram_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  membus_ram_responder_if.slave     bus,
  output logic [15:0]               oob_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    in_range;
  logic                    fire;

  assign word_idx = bus.bus_addr >> OFFS;
  assign in_range = (word_idx >> AW) == '0;

  // Gating with rst keeps ready and the response quiet while reset is held.
  assign bus.bus_ready  = (state == S_IDLE) & ~rst;
  assign bus.bus_rvalid = (state == S_RESP) & ~rst;
  assign bus.bus_rdata  = bus.bus_rvalid ? rdata_q : '0;
  assign fire           = bus.bus_valid & bus.bus_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (fire) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      oob_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fire) begin
        rdata_q <= (!bus.bus_wen && in_range) ? mem[word_idx[AW-1:0]] : '0;
        if (!in_range && oob_count != 16'hFFFF) oob_count <= oob_count + 16'd1;
      end
    end
  end

  // RAM array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (fire && bus.bus_wen && in_range) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.bus_wmask[i]) mem[word_idx[AW-1:0]][i*8 +: 8] <= bus.bus_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_membus_ram_responder.sv
// Directed bench for membus_ram_responder: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_membus_ram_responder;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic [15:0] oob1, oob3;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  membus_ram_responder_if b1 ();
  membus_ram_responder_if b3 ();

  membus_ram_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1), .oob_count(oob1));
  membus_ram_responder #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3), .oob_count(oob3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (sel == 1) begin
      b1.bus_valid = v; b1.bus_wen = w; b1.bus_addr = a; b1.bus_wdata = d; b1.bus_wmask = m;
    end else begin
      b3.bus_valid = v; b3.bus_wen = w; b3.bus_addr = a; b3.bus_wdata = d; b3.bus_wmask = m;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? b1.bus_ready : b3.bus_ready;
  endfunction

  function automatic logic rv(input int sel);
    return (sel == 1) ? b1.bus_rvalid : b3.bus_rvalid;
  endfunction

  function automatic logic [31:0] rd(input int sel);
    return (sel == 1) ? b1.bus_rdata : b3.bus_rdata;
  endfunction

  // One full request: accept, bounded wait for rvalid, check latency, data and single pulse.
  task automatic do_req(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] exp, input string tag);
    int   lat;
    int   cyc;
    logic seen;
    lat = (sel == 1) ? 1 : 3;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(rdy(sel)), 32'd1);
    drive(sel, 1'b1, w, a, d, m);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rv(sel)) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_rdata"}, rd(sel), exp);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, rv(sel)}, 32'd0);
  endtask

  initial begin
    int hits;
    rst1 = 1'b1;
    rst3 = 1'b1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    check("rst_ready1",  32'(b1.bus_ready), 32'd0);
    check("rst_rvalid1", 32'(b1.bus_rvalid), 32'd0);
    check("rst_rdata1",  b1.bus_rdata, 32'd0);
    check("rst_oob1",    32'(oob1), 32'd0);
    check("rst_ready3",  32'(b3.bus_ready), 32'd0);
    check("rst_oob3",    32'(oob3), 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    check("post_rst_ready1", 32'(b1.bus_ready), 32'd1);
    check("post_rst_ready3", 32'(b3.bus_ready), 32'd1);

    // Basic write then read.
    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "wr10");
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, "rd10");

    // Byte masks, including an all-zero mask that must leave the word alone.
    do_req(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, "wr20_full");
    do_req(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, "wr20_mask");
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd20_mask");
    do_req(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, "wr20_nomask");
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd20_nomask");

    // Out-of-range accesses must not alias onto word 0.
    do_req(1, 1'b1, 32'h0, 32'h13579BDF, 4'hF, 32'h0, "wr0");
    do_req(1, 1'b1, 32'h4000, 32'h5A5A5A5A, 4'hF, 32'h0, "wr_oob");
    do_req(1, 1'b0, 32'h4000, 32'h0, 4'h0, 32'h0, "rd_oob");
    check("oob_count2", 32'(oob1), 32'd2);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13579BDF, "rd0_after_oob");

    // Unaligned byte address ignores offset bits.
    do_req(1, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, "rd13");
    check("oob_count_unchanged", 32'(oob1), 32'd2);

    // LATENCY=3 instance: preload, then back-to-back reads with valid held high.
    do_req(3, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, "l3_wr0");
    do_req(3, 1'b1, 32'h4, 32'h01234567, 4'hF, 32'h0, "l3_wr4");
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check("b2b_rdy_a", 32'(b3.bus_ready), 32'd1);
    @(posedge clk);
    #1 b3.bus_addr = 32'h4;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b_a_busy%0d", k), 32'(b3.bus_ready), 32'd0);
      check($sformatf("b2b_a_rv%0d", k), 32'(b3.bus_rvalid), (k == 3) ? 32'd1 : 32'd0);
    end
    check("b2b_a_rdata", b3.bus_rdata, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b_rdy_b", 32'(b3.bus_ready), 32'd1);
    check("b2b_rv_gap", 32'(b3.bus_rvalid), 32'd0);
    @(posedge clk);
    #1 drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b_b_busy%0d", k), 32'(b3.bus_ready), 32'd0);
      check($sformatf("b2b_b_rv%0d", k), 32'(b3.bus_rvalid), (k == 3) ? 32'd1 : 32'd0);
    end
    check("b2b_b_rdata", b3.bus_rdata, 32'h01234567);

    // Reset one cycle after a read fires: the response is dropped, the earlier write survives.
    do_req(3, 1'b1, 32'h8, 32'h0BADC0DE, 4'hF, 32'h0, "l3_wr8");
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    @(posedge clk);
    #1 drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    check("midrst_ready", 32'(b3.bus_ready), 32'd0);
    check("midrst_rvalid", 32'(b3.bus_rvalid), 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("midrst_ready_after", 32'(b3.bus_ready), 32'd1);
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (b3.bus_rvalid) hits++;
    end
    check("midrst_no_rvalid", 32'(hits), 32'd0);
    do_req(3, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0BADC0DE, "l3_rd8_after_rst");
    check("oob3_zero", 32'(oob3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
